// File: rtl/control_unit_pkg.sv
// ----------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the REDUX-V main instruction decoder.
//   - OP / ULA_OP  : opcode and ALU-operation widths
//   - SIG_W        : width of the control vector
//   - OP_*         : the 16 opcode encodings
//   - SIG_*        : bit index of each control line inside the control vector
//   - ULA_*        : the 8 ALU operation codes
//   - sigBit()     : helper building a one-hot control vector from a bit index
// ----------------------------------------------------------------------------
package control_unit_pkg;

    localparam int OP     = 4;
    localparam int ULA_OP = 3;
    localparam int SIG_W  = 10;

    localparam logic [OP-1:0] OP_BRZR = 4'd0;
    localparam logic [OP-1:0] OP_JI   = 4'd1;
    localparam logic [OP-1:0] OP_LD   = 4'd2;
    localparam logic [OP-1:0] OP_ST   = 4'd3;
    localparam logic [OP-1:0] OP_ADDI = 4'd4;
    localparam logic [OP-1:0] OP_PUSH = 4'd5;
    localparam logic [OP-1:0] OP_POP  = 4'd6;
    localparam logic [OP-1:0] OP_MOV  = 4'd7;
    localparam logic [OP-1:0] OP_NOT  = 4'd8;
    localparam logic [OP-1:0] OP_AND  = 4'd9;
    localparam logic [OP-1:0] OP_OR   = 4'd10;
    localparam logic [OP-1:0] OP_XOR  = 4'd11;
    localparam logic [OP-1:0] OP_ADD  = 4'd12;
    localparam logic [OP-1:0] OP_SUB  = 4'd13;
    localparam logic [OP-1:0] OP_SLR  = 4'd14;
    localparam logic [OP-1:0] OP_SRR  = 4'd15;

    localparam int SIG_J   = 0;
    localparam int SIG_BR  = 1;
    localparam int SIG_RA  = 2;
    localparam int SIG_RE  = 3;
    localparam int SIG_WE  = 4;
    localparam int SIG_DM  = 5;
    localparam int SIG_SE  = 6;
    localparam int SIG_SP  = 7;
    localparam int SIG_SPR = 8;
    localparam int SIG_RD  = 9;

    localparam logic [ULA_OP-1:0] ULA_NOT = 3'd0;
    localparam logic [ULA_OP-1:0] ULA_AND = 3'd1;
    localparam logic [ULA_OP-1:0] ULA_OR  = 3'd2;
    localparam logic [ULA_OP-1:0] ULA_XOR = 3'd3;
    localparam logic [ULA_OP-1:0] ULA_ADD = 3'd4;
    localparam logic [ULA_OP-1:0] ULA_SUB = 3'd5;
    localparam logic [ULA_OP-1:0] ULA_SLR = 3'd6;
    localparam logic [ULA_OP-1:0] ULA_SRR = 3'd7;

    // One-hot control vector with only bit idx set; lets the decode table
    // be written as an OR of named control lines.
    function automatic logic [SIG_W-1:0] sigBit(input int idx);
        logic [SIG_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// ----------------------------------------------------------------------------
// control_unit_decode
// Pure combinational opcode -> control vector / ALU operation table.
// Ports:
//   op      in   OP      instruction opcode
//   signals out  SIG_W   control vector (one bit per datapath function)
//   ula_op  out  ULA_OP  ALU operation code (always op[ULA_OP-1:0])
// ----------------------------------------------------------------------------
module control_unit_decode
    import control_unit_pkg::*;
#(
    parameter int OP     = control_unit_pkg::OP,
    parameter int ULA_OP = control_unit_pkg::ULA_OP
) (
    input  logic [OP-1:0]                      op,
    output logic [control_unit_pkg::SIG_W-1:0] signals,
    output logic [ULA_OP-1:0]                  ula_op
);

    // The ALU opcodes 8..15 are laid out so their low bits are the ALU code,
    // and ADDI (4) lands on ADD, so no separate ALU table is needed.
    assign ula_op = op[ULA_OP-1:0];

    // Decode table; every control line not named for an opcode stays low.
    always_comb begin
        signals = '0;
        case (op)
            OP_BRZR: signals = sigBit(SIG_BR) | sigBit(SIG_RA);
            OP_JI:   signals = sigBit(SIG_J);
            OP_LD:   signals = sigBit(SIG_RA) | sigBit(SIG_RE) | sigBit(SIG_DM);
            OP_ST:   signals = sigBit(SIG_WE);
            OP_ADDI: signals = sigBit(SIG_SE) | sigBit(SIG_RE);
            OP_PUSH: signals = sigBit(SIG_RA) | sigBit(SIG_RE) | sigBit(SIG_WE)
                             | sigBit(SIG_DM) | sigBit(SIG_SP) | sigBit(SIG_SPR);
            OP_POP:  signals = sigBit(SIG_RA) | sigBit(SIG_RE) | sigBit(SIG_DM)
                             | sigBit(SIG_SP);
            OP_MOV:  signals = sigBit(SIG_RA) | sigBit(SIG_RE) | sigBit(SIG_RD);
            OP_NOT, OP_AND, OP_OR, OP_XOR,
            OP_ADD, OP_SUB, OP_SLR, OP_SRR:
                     signals = sigBit(SIG_RA) | sigBit(SIG_RE);
            default: signals = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Main instruction decoder of the REDUX-V core. Combinational decode for the
// single-cycle datapath plus a reset-cleared registered copy for a downstream
// pipeline/debug stage.
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       asynchronous active-high reset (clears registers)
//   flush     in   1       (CONTROL_UNIT_FLUSH_EN only) load a NOP bubble
//   op        in   OP      instruction opcode
//   signals   out  10      combinational control vector
//   ula_op    out  ULA_OP  combinational ALU operation
//   signals_q out  10      signals registered on clk
//   ula_op_q  out  ULA_OP  ula_op registered on clk
// Build option: define CONTROL_UNIT_FLUSH_EN to add the flush input.
// ----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
#(
    parameter int OP     = control_unit_pkg::OP,
    parameter int ULA_OP = control_unit_pkg::ULA_OP
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef CONTROL_UNIT_FLUSH_EN
    input  logic                               flush,
`endif
    input  logic [OP-1:0]                      op,
    output logic [control_unit_pkg::SIG_W-1:0] signals,
    output logic [ULA_OP-1:0]                  ula_op,
    output logic [control_unit_pkg::SIG_W-1:0] signals_q,
    output logic [ULA_OP-1:0]                  ula_op_q
);

    logic [SIG_W-1:0]  signals_d;
    logic [ULA_OP-1:0] ula_op_d;

    control_unit_decode #(
        .OP     (OP),
        .ULA_OP (ULA_OP)
    ) u_decode (
        .op      (op),
        .signals (signals),
        .ula_op  (ula_op)
    );

    // Next value of the output register: the live decode, or an all-zero
    // bubble when the downstream stage asks for a flush.
`ifdef CONTROL_UNIT_FLUSH_EN
    always_comb begin
        signals_d = signals;
        ula_op_d  = ula_op;
        if (flush) begin
            signals_d = '0;
            ula_op_d  = '0;
        end
    end
`else
    always_comb begin
        signals_d = signals;
        ula_op_d  = ula_op;
    end
`endif

    // Output register; reset clears it at once and overrides any flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signals_q <= '0;
            ula_op_q  <= '0;
        end else begin
            signals_q <= signals_d;
            ula_op_q  <= ula_op_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit. Expected values come from a small
// reference table in the bench, pushed to scoreboard queues when stimulus is
// applied and popped when the DUT output is sampled.
// Build option: define CONTROL_UNIT_FLUSH_EN to also exercise flush.
// ----------------------------------------------------------------------------
module tb_control_unit;

    typedef struct {
        string      tag;
        logic [9:0] sig;
        logic [2:0] ula;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] op;
    logic [9:0] signals;
    logic [2:0] ula_op;
    logic [9:0] signals_q;
    logic [2:0] ula_op_q;
`ifdef CONTROL_UNIT_FLUSH_EN
    logic       flush;
`endif

    exp_t combQ[$];
    exp_t regQ[$];
    int   checks;
    int   failures;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CONTROL_UNIT_FLUSH_EN
        .flush     (flush),
`endif
        .op        (op),
        .signals   (signals),
        .ula_op    (ula_op),
        .signals_q (signals_q),
        .ula_op_q  (ula_op_q)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode table written out as plain constants.
    function automatic logic [9:0] modelSig(input logic [3:0] o);
        case (o)
            4'd0:    return 10'h006;
            4'd1:    return 10'h001;
            4'd2:    return 10'h02C;
            4'd3:    return 10'h010;
            4'd4:    return 10'h048;
            4'd5:    return 10'h1BC;
            4'd6:    return 10'h0AC;
            4'd7:    return 10'h20C;
            default: return 10'h00C;
        endcase
    endfunction

    // Push one expectation onto the combinational or registered scoreboard.
    task automatic pushExp(input bit isReg, input string tag,
                           input logic [9:0] sig, input logic [2:0] ula);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.ula = ula;
        if (isReg) regQ.push_back(e);
        else       combQ.push_back(e);
    endtask

    // Drive an opcode and record the combinational result it must produce.
    task automatic applyStimulus(input logic [3:0] o, input string tag);
        op = o;
        pushExp(1'b0, tag, modelSig(o), o[2:0]);
    endtask

    // Pop the oldest expectation of the chosen kind and compare both fields.
    task automatic checkOutput(input bit isReg);
        exp_t       e;
        logic [9:0] obsSig;
        logic [2:0] obsUla;
        checks++;
        if ((isReg && regQ.size() == 0) || (!isReg && combQ.size() == 0)) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=empty expected=entry");
            return;
        end
        e      = isReg ? regQ.pop_front() : combQ.pop_front();
        obsSig = isReg ? signals_q : signals;
        obsUla = isReg ? ula_op_q  : ula_op;
        assert (obsSig === e.sig && obsUla === e.ula) else begin
            failures++;
            $display("[TB] FAIL %s %s observed sig=%h ula=%0d expected sig=%h ula=%0d",
                     e.tag, isReg ? "reg" : "comb", obsSig, obsUla, e.sig, e.ula);
            $error("[TB] comparison %s did not hold", e.tag);
        end
    endtask

    initial begin
        logic [3:0] r;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        op       = 4'd0;
`ifdef CONTROL_UNIT_FLUSH_EN
        flush    = 1'b0;
`endif
        #2;
        pushExp(1'b1, "reset_state", 10'h000, 3'd0);
        checkOutput(1'b1);

        // Full opcode sweep of the combinational decode.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i), $sformatf("sweep_op%0d", i));
            #1;
            checkOutput(1'b0);
        end

        // Load PUSH, then assert reset mid-cycle.
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'd5, "push_comb");
        @(posedge clk);
        #1;
        pushExp(1'b1, "push_load", 10'h1BC, 3'd5);
        checkOutput(1'b1);
        #2;
        rst = 1'b1;
        #1;
        pushExp(1'b1, "async_rst", 10'h000, 3'd0);
        checkOutput(1'b1);
        checkOutput(1'b0);

        // Release reset, load ADD, then hold between edges.
        @(negedge clk);
        rst = 1'b0;
        op  = 4'd12;
        @(posedge clk);
        #1;
        pushExp(1'b1, "add_load", 10'h00C, 3'd4);
        checkOutput(1'b1);
        @(negedge clk);
        applyStimulus(4'd3, "st_comb");
        #1;
        pushExp(1'b1, "hold_between_edges", 10'h00C, 3'd4);
        checkOutput(1'b1);
        checkOutput(1'b0);
        @(posedge clk);
        #1;
        pushExp(1'b1, "st_load", 10'h010, 3'd3);
        checkOutput(1'b1);

`ifdef CONTROL_UNIT_FLUSH_EN
        // Flush inserts a bubble; combinational path is untouched.
        @(negedge clk);
        applyStimulus(4'd6, "pop_comb_flush");
        flush = 1'b1;
        @(posedge clk);
        #1;
        pushExp(1'b1, "flush_bubble", 10'h000, 3'd0);
        checkOutput(1'b1);
        checkOutput(1'b0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        pushExp(1'b1, "pop_after_flush", 10'h0AC, 3'd6);
        checkOutput(1'b1);
`endif

        // Reset held across an edge keeps the register cleared.
        @(negedge clk);
        rst = 1'b1;
        op  = 4'd7;
        @(posedge clk);
        #1;
        pushExp(1'b1, "rst_wins", 10'h000, 3'd0);
        checkOutput(1'b1);

        // Random opcodes through the registered path.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r  = 4'($urandom_range(0, 15));
            op = r;
            pushExp(1'b1, $sformatf("rand_reg%0d_op%0d", k, r), modelSig(r), r[2:0]);
            @(posedge clk);
            #1;
            checkOutput(1'b1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main instruction decoder of the REDUX-V core.
- Maps the 4-bit opcode to a 10-bit one-hot-per-function control vector and a 3-bit ALU (ULA) operation code.
- Decode is purely combinational so the single-cycle datapath sees it in the same cycle.
- A reset-cleared registered copy is also provided for a downstream pipeline or debug stage.

Parameters:
- OP, 4, opcode width. Must equal package constant OP.
- ULA_OP, 3, ALU op width. Must equal package constant ULA_OP.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  OP  instruction opcode.
- signals  out  10  combinational control vector.
- ula_op  out  ULA_OP  combinational ALU operation.
- signals_q  out  10  signals registered on clk.
- ula_op_q  out  ULA_OP  ula_op registered on clk.

Behaviour:
- Opcode map: BRZR=0, JI=1, LD=2, ST=3, ADDI=4, PUSH=5, POP=6, MOV=7, NOT=8, AND=9, OR=10, XOR=11, ADD=12, SUB=13, SLR=14, SRR=15.
- Signal bit indices:
  - J=0 (jump immediate)
  - BR=1 (branch if zero)
  - RA=2 (register operand A used)
  - RE=3 (register-file write enable)
  - WE=4 (data-memory write enable)
  - DM=5 (write-back from memory)
  - SE=6 (sign-extended immediate to ALU B)
  - SP=7 (stack-pointer update)
  - SPR=8 (SP pre-decrement, push direction)
  - RD=9 (register move bypasses ALU)
- signals per opcode; every bit not listed is 0:
  - BRZR: BR|RA = 0x006
  - JI: J = 0x001
  - LD: RA|RE|DM = 0x02C
  - ST: WE = 0x010
  - ADDI: SE|RE = 0x048
  - PUSH: RA|RE|WE|DM|SP|SPR = 0x1BC
  - POP: RA|RE|DM|SP = 0x0AC
  - MOV: RA|RE|RD = 0x20C
  - NOT..SRR: RA|RE = 0x00C
- ula_op = op[2:0] for every opcode.
  - ALU ops 8..15 yield 0..7 (NOT=0, AND=1, OR=2, XOR=3, ADD=4, SUB=5, SLR=6, SRR=7).
  - ADDI yields 4, i.e. ADD.
  - Non-ALU opcodes pass op[2:0]; the datapath ignores it.
- Combinational outputs:
  - Zero latency; no latches.
  - Full case with a default of all-zero signals.
  - Outputs follow op asynchronously, independent of clk/rst.
- Registered outputs:
  - signals_q/ula_op_q load signals/ula_op on each rising clk edge.
  - rst asserted at any time forces both to 0 immediately; they hold 0 while rst is high.
  - The first load is on the first rising edge after rst deasserts.
- X/Z on op: combinational outputs may be X; no other requirement.

Optional Feature:
- Macro: CONTROL_UNIT_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit).
  - flush high at a rising edge loads 0 into signals_q/ula_op_q, a bubble/NOP.
  - rst has priority over flush.
  - Combinational outputs are unaffected by flush.
- Undefined: no flush port; registers always load the decode.

Decomposition:
- Shared package/header (utils.vh):
  - OP and ULA_OP widths.
  - All 16 opcode constants.
  - The 10 signal bit-index constants.
  - The 8 ALU op codes.
  - ASSERT macro.
- Natural sub-module: control_decode, the pure combinational opcode-to-signals/ula_op table.
  - control_unit wraps it and adds the output register and optional flush.

Test Plan:
- Sweep op 0..15, no clock needed.
  - signals must match the table: op=0 -> 0x006, 1 -> 0x001, 2 -> 0x02C, 3 -> 0x010, 4 -> 0x048, 5 -> 0x1BC, 6 -> 0x0AC, 7 -> 0x20C, 8..15 -> 0x00C.
  - ula_op must equal op[2:0] throughout: op=4 -> 4, op=9 -> 1, op=15 -> 7.
- Assert rst asynchronously mid-cycle after loading op=5.
  - signals_q drops 0x1BC -> 0x000 and ula_op_q drops 5 -> 0 without a clock edge.
  - Combinational signals stay 0x1BC.
- Release rst, op=12, one rising edge.
  - signals_q=0x00C, ula_op_q=4.
  - Change op to 3 between edges: signals_q holds 0x00C until the next edge, then 0x010.
- With CONTROL_UNIT_FLUSH_EN: op=6, flush=1 at an edge.
  - signals_q=0, ula_op_q=0.
  - Next edge with flush=0 gives signals_q=0x0AC, ula_op_q=6.
- Same edge with rst=1 and flush=0: register is 0. rst wins.
